// File: rtl/evr_pkg.sv
// Shared types and default constants for the EVR clock-path phase-shift
// sequencer.
//   ps_state_t  : sequencer FSM states
//   ps_status_t : sticky error flags as reported to the register block,
//                 packed MSB-first as {limit_hit, timeout, overflow}
package evr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    SETTLE = 2'd3
  } ps_state_t;

  typedef struct packed {
    logic limit_hit;
    logic timeout;
    logic overflow;
  } ps_status_t;

  localparam int POS_LIMIT_DEF      = 2240;
  localparam int SETTLE_CYCLES_DEF  = 4;
  localparam int TIMEOUT_CYCLES_DEF = 64;

endpackage

// File: rtl/mmcm_ps_ctrl.sv
// MMCM dynamic phase-shift sequencer (psclk domain).
// Queues single-step inc/dec requests in a signed saturating counter and
// issues them one at a time on psen/psincdec, waiting for psdone and then a
// fixed settle interval before the next step. Tracks the accumulated phase
// position, refuses steps beyond +/-POS_LIMIT, and keeps sticky error flags.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   ena           link ready; low flushes the queue, zeroes pos, forces IDLE
//   inc_req       one-cycle request for a +1 step
//   dec_req       one-cycle request for a -1 step
//   clr_err       one-cycle pulse clearing the sticky status flags
//   psen          one-cycle phase-shift enable pulse to the MMCM
//   psincdec      step direction (1 = increment), held until the next step
//   psdone        MMCM step completion pulse
//   busy          FSM not idle or steps still queued
//   pending       signed count of queued, not yet issued steps
//   pos           signed accumulated phase position
//   status        sticky {limit_hit, timeout, overflow}
module mmcm_ps_ctrl
  import evr_pkg::*;
#(
  parameter int PEND_W         = 8,
  parameter int POS_W          = 16,
  parameter int POS_LIMIT      = POS_LIMIT_DEF,
  parameter int SETTLE_CYCLES  = SETTLE_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              inc_req,
  input  logic              dec_req,
  input  logic              clr_err,
  output logic              psen,
  output logic              psincdec,
  input  logic              psdone,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic [POS_W-1:0]  pos,
  output logic [2:0]        status
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);

  localparam logic signed [PEND_W-1:0] PEND_ONE = PEND_W'(1);
  localparam logic signed [PEND_W-1:0] PEND_MAX = {1'b0, {(PEND_W-1){1'b1}}};
  localparam logic signed [PEND_W-1:0] PEND_MIN = -PEND_MAX;

  localparam logic signed [POS_W-1:0] POS_ONE = POS_W'(1);
  localparam logic signed [POS_W-1:0] POS_MAX = POS_W'(POS_LIMIT);
  localparam logic signed [POS_W-1:0] POS_MIN = -POS_MAX;

  // Elaboration-time parameter sanity checks.
  if (longint'(POS_LIMIT) > ((longint'(1) << (POS_W - 1)) - 1) || POS_LIMIT < 1) begin : g_bad_pos_limit
    $error("mmcm_ps_ctrl: POS_LIMIT must be in 1 .. 2**(POS_W-1)-1");
  end
  if (PEND_W < 2) begin : g_bad_pend_w
    $error("mmcm_ps_ctrl: PEND_W must be at least 2");
  end
  if (SETTLE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cycles
    $error("mmcm_ps_ctrl: SETTLE_CYCLES and TIMEOUT_CYCLES must be at least 1");
  end

  ps_state_t               state_q, state_d;
  logic signed [PEND_W-1:0] pend_q, pend_d, pend_c, consume;
  logic signed [POS_W-1:0]  pos_q, pos_d;
  logic                     psinc_q, psinc_d;
  logic [TMO_W-1:0]         tmo_q, tmo_d;
  logic [SET_W-1:0]         set_q, set_d;
  ps_status_t               status_q, status_d;

  logic pend_pos, pend_neg, req_up, req_dn;
  logic set_limit, set_tmo, set_ovf;

  assign pend_neg = pend_q[PEND_W-1];
  assign pend_pos = !pend_q[PEND_W-1] && (pend_q != '0);

  // Simultaneous inc and dec cancel out.
  assign req_up = inc_req & ~dec_req;
  assign req_dn = dec_req & ~inc_req;

  // Step sequencing, position tracking and queue bookkeeping.
  always_comb begin
    state_d   = state_q;
    psinc_d   = psinc_q;
    pos_d     = pos_q;
    tmo_d     = tmo_q;
    set_d     = set_q;
    consume   = '0;
    set_limit = 1'b0;
    set_tmo   = 1'b0;
    set_ovf   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A queued step at the position limit is dropped rather than issued,
        // so the queue drains instead of stalling.
        if (pend_pos) begin
          consume = PEND_ONE;
          if (pos_q < POS_MAX) begin
            state_d = ISSUE;
            psinc_d = 1'b1;
          end else begin
            set_limit = 1'b1;
          end
        end else if (pend_neg) begin
          consume = -PEND_ONE;
          if (pos_q > POS_MIN) begin
            state_d = ISSUE;
            psinc_d = 1'b0;
          end else begin
            set_limit = 1'b1;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
        tmo_d   = '0;
      end
      WAIT: begin
        // psdone wins over an expiry in the same cycle.
        if (psdone) begin
          pos_d   = psinc_q ? pos_q + POS_ONE : pos_q - POS_ONE;
          set_d   = '0;
          state_d = SETTLE;
        end else if (tmo_q == TMO_LAST) begin
          set_tmo = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      SETTLE: begin
        if (set_q == SET_LAST) state_d = IDLE;
        else                   set_d   = set_q + SET_W'(1);
      end
      default: state_d = IDLE;
    endcase

    // consume always points toward zero, so pend_c stays in range; only the
    // new request can push past saturation, and then it is the one dropped.
    pend_c = pend_q - consume;
    pend_d = pend_c;
    if (req_up) begin
      if (pend_c == PEND_MAX) set_ovf = 1'b1;
      else                    pend_d  = pend_c + PEND_ONE;
    end else if (req_dn) begin
      if (pend_c == PEND_MIN) set_ovf = 1'b1;
      else                    pend_d  = pend_c - PEND_ONE;
    end

    // Clear first so a same-cycle set survives; nothing sets while ena is low.
    status_d = clr_err ? '0 : status_q;
    if (ena) begin
      if (set_limit) status_d.limit_hit = 1'b1;
      if (set_tmo)   status_d.timeout   = 1'b1;
      if (set_ovf)   status_d.overflow  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pend_q   <= '0;
      pos_q    <= '0;
      psinc_q  <= 1'b0;
      tmo_q    <= '0;
      set_q    <= '0;
      status_q <= '0;
    end else if (!ena) begin
      // Link down: the MMCM relocks at zero phase, so forget everything but
      // the error history and the last direction.
      state_q  <= IDLE;
      pend_q   <= '0;
      pos_q    <= '0;
      tmo_q    <= '0;
      set_q    <= '0;
      status_q <= status_d;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      pos_q    <= pos_d;
      psinc_q  <= psinc_d;
      tmo_q    <= tmo_d;
      set_q    <= set_d;
      status_q <= status_d;
    end
  end

  // ISSUE lasts exactly one cycle, so psen is a single-cycle pulse.
  assign psen     = (state_q == ISSUE);
  assign psincdec = psinc_q;
  assign busy     = (state_q != IDLE) || (pend_q != '0);
  assign pending  = pend_q;
  assign pos      = pos_q;
  assign status   = status_q;

endmodule

// File: doc/mmcm_ps_ctrl.md
Name: mmcm_ps_ctrl

Overview:
Sequencer for the MMCM dynamic phase-shift port in the EVR clock path. It queues single-step increment/decrement requests from the delay-compensation logic and issues them one at a time on psen/psincdec. For each step it waits for psdone, then settles. It tracks the accumulated phase position, enforces a position limit, and reports sticky errors to the EVR register block.

Parameters:
PEND_W, 8, width of the signed pending-step counter
POS_W, 16, width of the signed accumulated-position counter
POS_LIMIT, 2240, maximum allowed |pos| in MMCM phase steps
SETTLE_CYCLES, 4, idle cycles enforced after each psdone before the next step
TIMEOUT_CYCLES, 64, cycles to wait for psdone before aborting the step

Ports:
clk  in  1  phase-shift clock (psclk domain)
rst  in  1  synchronous, active-high reset
ena  in  1  link-ready qualifier; low = flush and hold
inc_req  in  1  single-cycle request for one +step
dec_req  in  1  single-cycle request for one -step
clr_err  in  1  single-cycle pulse; clears sticky status bits
psen  out  1  MMCM phase-shift enable, one-cycle pulse per step
psincdec  out  1  MMCM direction, 1 = increment; valid while psen=1
psdone  in  1  MMCM step completion pulse
busy  out  1  high when state != IDLE or pending != 0
pending  out  PEND_W  signed count of queued steps not yet issued
pos  out  POS_W  signed accumulated phase position
status  out  3  sticky flags {limit_hit, timeout, overflow}

Behaviour:
- Reset: psen=0, psincdec=0, pending=0, pos=0, status=0, state=IDLE, all counters 0, busy=0.
- Pending counter update (per cycle):
  - pending_next = pending + inc_req − dec_req − consume, where consume = ±1 when a step is issued or dropped.
  - inc_req and dec_req together contribute net zero.
  - Saturates at ±(2^(PEND_W−1)−1). A request that would exceed saturation is dropped and sets overflow.
- FSM states: IDLE, ISSUE, WAIT, SETTLE.
  - IDLE:
    - If ena and pending>0 and pos<POS_LIMIT: go to ISSUE, psincdec=1, consume +1.
    - If ena and pending<0 and pos>−POS_LIMIT: go to ISSUE, psincdec=0, consume −1.
    - If pending is non-zero but pos is at the limit in that direction: drop one step (consume), set limit_hit, stay in IDLE.
  - ISSUE: psen=1 for exactly this cycle, then go to WAIT; clear the timeout counter.
  - WAIT:
    - On psdone: pos ±1 per psincdec, go to SETTLE.
    - If the timeout counter reaches TIMEOUT_CYCLES−1 without psdone: set timeout, pos unchanged, go to IDLE.
  - SETTLE: count SETTLE_CYCLES cycles, then go to IDLE.
- Latency:
  - A request pulse in cycle N gives pending=±1 in cycle N+1 and psen=1 in cycle N+2.
  - Back-to-back step issue spacing = 1 (ISSUE) + WAIT duration + SETTLE_CYCLES + 1 (IDLE decision).
- psdone while in IDLE, ISSUE or SETTLE is ignored; no state or pos change.
- psen is never high for more than one consecutive cycle. psincdec holds its value from ISSUE until the next ISSUE.
- ena low, any state:
  - Next cycle: pending=0, pos=0 (the MMCM relocks at zero phase), state=IDLE, psen=0.
  - Requests arriving while ena=0 are discarded.
  - status is preserved.
- clr_err clears all status bits next cycle. If a flag-setting event occurs in the same cycle, the set wins.
- Width rules: pos is compared in signed POS_W arithmetic. POS_LIMIT must be ≤ 2^(POS_W−1)−1; an elaboration-time assertion checks this.
- Mid-operation rst: same as power-on reset, effective the next edge regardless of state.

Decomposition:
- Package evr_pkg holds:
  - ps_state_t enum {IDLE, ISSUE, WAIT, SETTLE}
  - ps_status_t packed struct {limit_hit, timeout, overflow}
  - default constants for POS_LIMIT, SETTLE_CYCLES and TIMEOUT_CYCLES
- Single flat module; no sub-module warranted.

Test Plan:
- Single step: ena=1, one inc_req pulse at cycle 0, psdone returned 5 cycles after psen → psen=1 at cycle 2 with psincdec=1; pos=+1; busy low after SETTLE_CYCLES+1; status=0.
- Queueing: 3 inc_req pulses plus 1 dec_req pulse, all simultaneous with the first inc → pending peaks at 2; exactly 2 psen pulses, each separated by psdone plus 4 settle cycles; final pos=+2.
- Timeout: dec_req, psdone never returned → after 64 WAIT cycles status=3'b010, pos=0, FSM in IDLE; a second dec_req then completes normally with pos=−1.
- Limit: POS_LIMIT=2, 4 inc_req with psdone returned → pos=2, two steps dropped without psen, status=3'b100; clr_err → status=0.
- Overflow: PEND_W=3, 5 inc_req while psdone is withheld → pending saturates at 3, overflow set.
- ena drop mid-WAIT: ena=0 during WAIT with pending=2 → next cycle pending=0, pos=0, IDLE, psen=0; a late psdone has no effect.
